cpu_top: RTL and testbench

- Five-stage in-order RV32I-subset pipeline core (IF, ID, EX, MEM, WB) with forwarding, load-use stall and branch flush.
- Fetches through an external instruction memory and accesses an external data memory; both are instances of the companion word memory `mem`, which is specified in the Decomposition section.
- Sits at the top of the CPU hierarchy; the bench instantiates the core plus two `mem` instances.

---
 rtl/cpu_top_pkg.sv | 112 +++++++++++
 rtl/cpu_top_reg_file.sv | 38 +++
 rtl/mem.sv | 23 ++
 rtl/cpu_top.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_top.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_top_pkg.sv
// Shared encodings, pipeline register layouts and ALU helpers for the cpu_top core.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package cpu_top_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 bit 5 (instruction bit 30) selects sub / sra
    localparam int F7_ALT_BIT = 30;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
    } alu_op_t;

    typedef enum logic [1:0] {FWD_NONE, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;

    typedef struct packed {
        logic [31:0] pc_IF;
        logic [31:0] ir;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_t     alu_op;
        logic        a_pc;
        logic        b_imm;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jal;
        logic        jalr;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store_dat;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } exmem_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] readdata_WB;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
    } memwb_t;

    // Map funct3/alt bit to an ALU op; sub only exists for register-register ops
    function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_t op;
        case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_fn(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_SUB:   r = a - b;
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_SLL:   r = a << b[4:0];
            ALU_SRL:   r = a >> b[4:0];
            ALU_SRA:   r = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:   r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {31'b0, a < b};
            ALU_PASSB: r = b;
            default:   r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_top_reg_file.sv
// 32x32 register file, two read ports and one write port, x0 hardwired to zero.
// Latency: combinational read; a same-cycle write is bypassed to the read ports.
// Backpressure: none.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] registers [0:31];
    logic        wr_hit;

    assign wr_hit = we && (wa != 5'd0);

    // clear on reset, otherwise commit the WB write (never to x0)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (wr_hit) begin
            registers[wa] <= wd;
        end
    end

    // read ports see the value being written this cycle
    always_comb begin
        rd1 = registers[ra1];
        rd2 = registers[ra2];
        if (wr_hit && wa == ra1) rd1 = wd;
        if (wr_hit && wa == ra2) rd2 = wd;
    end
endmodule

// File: rtl/mem.sv
// Word-addressed 256x32 memory used for both instruction and data storage.
// Latency: combinational read, write committed on the rising clk edge.
// Backpressure: none; always ready.
module mem (
    input  logic        clk,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:255];
    logic        unused_addr;

    assign unused_addr = ^{addr[31:10], addr[1:0]};
    assign rdata       = mem[addr[9:2]];

    // synchronous word write
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr[9:2]] <= wdata;
        end
    end
endmodule

// File: rtl/cpu_top.sv
// Five-stage in-order RV32I-subset core with forwarding, load-use stall and EX branch resolution.
// Latency: ALU result lands in the register file 5 cycles after fetch; taken branch/jump costs 2 cycles.
// Backpressure: none external; load-use holds PC/IFID one cycle and injects an EX bubble.
module cpu_top import cpu_top_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ir,
    input  logic [XLEN-1:0] readdata_MEM,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] alu_DMEM,
    output logic [XLEN-1:0] writedata_DMEM,
    output logic            memwrite_MEM
);
    logic [31:0] pc;
    ifid_t       IFID;
    idex_t       IDEX;
    exmem_t      EXMEM;
    memwb_t      MEMWB;

    idex_t       id_dec;
    logic [6:0]  id_opc;
    logic [2:0]  id_f3;
    logic [4:0]  id_rs1, id_rs2;
    logic        use_rs1, use_rs2;
    logic [31:0] rf_rd1, rf_rd2, wb_dat;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    fwd_sel_t    fwd_a, fwd_b;
    logic [31:0] op_a, op_b, alu_a, alu_b, ex_result;
    logic        br_taken, redirect, load_use, stall;
    logic [31:0] redirect_pc;

    assign pc_out         = pc;
    assign alu_DMEM       = EXMEM.alu;
    assign writedata_DMEM = EXMEM.store_dat;
    assign memwrite_MEM   = EXMEM.memwrite;

    assign id_opc = IFID.ir[6:0];
    assign id_f3  = IFID.ir[14:12];
    assign id_rs1 = IFID.ir[19:15];
    assign id_rs2 = IFID.ir[24:20];
    assign imm_i  = {{20{IFID.ir[31]}}, IFID.ir[31:20]};
    assign imm_s  = {{20{IFID.ir[31]}}, IFID.ir[31:25], IFID.ir[11:7]};
    assign imm_b  = {{19{IFID.ir[31]}}, IFID.ir[31], IFID.ir[7], IFID.ir[30:25], IFID.ir[11:8], 1'b0};
    assign imm_u  = {IFID.ir[31:12], 12'b0};
    assign imm_j  = {{11{IFID.ir[31]}}, IFID.ir[31], IFID.ir[19:12], IFID.ir[20], IFID.ir[30:21], 1'b0};

    assign wb_dat = MEMWB.memread ? MEMWB.readdata_WB : MEMWB.alu;

    reg_file regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (id_rs1),
        .ra2 (id_rs2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (MEMWB.regwrite),
        .wa  (MEMWB.rd),
        .wd  (wb_dat)
    );

    // ID: decode into EX controls; unknown opcodes leave every control bit clear (NOP)
    always_comb begin
        id_dec         = '0;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        id_dec.pc      = IFID.pc_IF;
        id_dec.rs1     = id_rs1;
        id_dec.rs2     = id_rs2;
        id_dec.rd      = IFID.ir[11:7];
        id_dec.funct3  = id_f3;
        id_dec.rs1_val = rf_rd1;
        id_dec.rs2_val = rf_rd2;
        id_dec.alu_op  = ALU_ADD;
        case (id_opc)
            OP_REG: begin
                id_dec.regwrite = 1'b1;
                id_dec.alu_op   = decode_alu(id_f3, IFID.ir[F7_ALT_BIT], 1'b1);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM: begin
                id_dec.regwrite = 1'b1;
                id_dec.b_imm    = 1'b1;
                id_dec.imm      = imm_i;
                id_dec.alu_op   = decode_alu(id_f3, IFID.ir[F7_ALT_BIT], 1'b0);
                use_rs1 = 1'b1;
            end
            OP_LUI: begin
                id_dec.regwrite = 1'b1;
                id_dec.b_imm    = 1'b1;
                id_dec.imm      = imm_u;
                id_dec.alu_op   = ALU_PASSB;
            end
            OP_AUIPC: begin
                id_dec.regwrite = 1'b1;
                id_dec.a_pc     = 1'b1;
                id_dec.b_imm    = 1'b1;
                id_dec.imm      = imm_u;
            end
            OP_LOAD: begin
                if (id_f3 == F3_WORD) begin
                    id_dec.regwrite = 1'b1;
                    id_dec.memread  = 1'b1;
                    id_dec.b_imm    = 1'b1;
                    id_dec.imm      = imm_i;
                    use_rs1 = 1'b1;
                end
            end
            OP_STORE: begin
                if (id_f3 == F3_WORD) begin
                    id_dec.memwrite = 1'b1;
                    id_dec.b_imm    = 1'b1;
                    id_dec.imm      = imm_s;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (id_f3 != 3'b010 && id_f3 != 3'b011) begin
                    id_dec.branch = 1'b1;
                    id_dec.imm    = imm_b;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OP_JAL: begin
                id_dec.regwrite = 1'b1;
                id_dec.jal      = 1'b1;
                id_dec.imm      = imm_j;
            end
            OP_JALR: begin
                id_dec.regwrite = 1'b1;
                id_dec.jalr     = 1'b1;
                id_dec.imm      = imm_i;
                use_rs1 = 1'b1;
            end
            default: ;
        endcase
    end

    // a load in EX cannot forward in time to the instruction now in ID
    assign load_use = IDEX.memread && (IDEX.rd != 5'd0) &&
                      ((use_rs1 && IDEX.rd == id_rs1) || (use_rs2 && IDEX.rd == id_rs2));
    // a redirect flushes ID anyway, so it overrides the stall
    assign stall = load_use && !redirect;

    // EX operand source selection: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (EXMEM.regwrite && EXMEM.rd != 5'd0 && EXMEM.rd == IDEX.rs1)      fwd_a = FWD_EXMEM;
        else if (MEMWB.regwrite && MEMWB.rd != 5'd0 && MEMWB.rd == IDEX.rs1) fwd_a = FWD_MEMWB;
        if (EXMEM.regwrite && EXMEM.rd != 5'd0 && EXMEM.rd == IDEX.rs2)      fwd_b = FWD_EXMEM;
        else if (MEMWB.regwrite && MEMWB.rd != 5'd0 && MEMWB.rd == IDEX.rs2) fwd_b = FWD_MEMWB;
    end

    // EX datapath: operand muxes, ALU, branch compare and redirect target
    always_comb begin
        case (fwd_a)
            FWD_EXMEM: op_a = EXMEM.alu;
            FWD_MEMWB: op_a = wb_dat;
            default:   op_a = IDEX.rs1_val;
        endcase
        case (fwd_b)
            FWD_EXMEM: op_b = EXMEM.alu;
            FWD_MEMWB: op_b = wb_dat;
            default:   op_b = IDEX.rs2_val;
        endcase
        alu_a     = IDEX.a_pc  ? IDEX.pc  : op_a;
        alu_b     = IDEX.b_imm ? IDEX.imm : op_b;
        ex_result = (IDEX.jal || IDEX.jalr) ? IDEX.pc + 32'd4 : alu_fn(IDEX.alu_op, alu_a, alu_b);
        case (IDEX.funct3)
            F3_BEQ:  br_taken = (op_a == op_b);
            F3_BNE:  br_taken = (op_a != op_b);
            F3_BLT:  br_taken = ($signed(op_a) <  $signed(op_b));
            F3_BGE:  br_taken = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: br_taken = (op_a <  op_b);
            F3_BGEU: br_taken = (op_a >= op_b);
            default: br_taken = 1'b0;
        endcase
        redirect    = IDEX.jal || IDEX.jalr || (IDEX.branch && br_taken);
        redirect_pc = IDEX.jalr ? ((op_a + IDEX.imm) & ~32'd1) : (IDEX.pc + IDEX.imm);
    end

    // PC: reset, redirect, hold on load-use, else sequential fetch
    always_ff @(posedge clk) begin
        if (rst)           pc <= RESET_PC;
        else if (redirect) pc <= redirect_pc;
        else if (!stall)   pc <= pc + 32'd4;
    end

    // IF/ID: flushed to NOP on redirect, frozen on load-use
    always_ff @(posedge clk) begin
        if (rst || redirect) IFID <= '{pc_IF: 32'd0, ir: NOP_INSTR};
        else if (!stall)     IFID <= '{pc_IF: pc, ir: ir};
    end

    // ID/EX: bubble on reset, redirect or load-use
    always_ff @(posedge clk) begin
        if (rst || redirect || stall) IDEX <= '0;
        else                          IDEX <= id_dec;
    end

    // EX/MEM: result plus forwarded rs2 as store data
    always_ff @(posedge clk) begin
        if (rst) EXMEM <= '0;
        else     EXMEM <= '{alu: ex_result, store_dat: op_b, rd: IDEX.rd,
                            regwrite: IDEX.regwrite, memread: IDEX.memread, memwrite: IDEX.memwrite};
    end

    // MEM/WB: capture load data from data memory alongside the ALU result
    always_ff @(posedge clk) begin
        if (rst) MEMWB <= '0;
        else     MEMWB <= '{alu: EXMEM.alu, readdata_WB: readdata_MEM, rd: EXMEM.rd,
                            regwrite: EXMEM.regwrite, memread: EXMEM.memread};
    end
endmodule

// File: tb/tb_cpu_top.sv
// Directed bench: core plus instruction/data memories, program tables with expected register values.
// Latency: cycle-exact checks of PC trace, store pulse and WB timing.
// Backpressure: not applicable.
module tb_cpu_top;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPJR = 7'b1100111;
    localparam logic [6:0] OPLUI = 7'b0110111;
    localparam logic [6:0] OPAUI = 7'b0010111;

    logic        clk;
    logic        rst;
    logic        loading, ld_wen;
    logic [31:0] ld_addr, ld_dat;
    logic [31:0] ir, readdata_MEM, pc_out, alu_DMEM, writedata_DMEM;
    logic        memwrite_MEM;
    logic [31:0] imem_addr;

    int total = 0;
    int bad   = 0;
    int mw_cnt;

    typedef struct {
        logic [31:0] instr;
        int          chk_reg;
        logic [31:0] chk_val;
    } vec_t;

    vec_t        prog_a [29];
    vec_t        prog_b [12];
    logic [31:0] img [0:255];
    logic [31:0] trace_a [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                                  32'h18, 32'h18, 32'h1C, 32'h20, 32'h20, 32'h24};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_addr = loading ? ld_addr : pc_out;

    cpu_top #(.RESET_PC(32'h0), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ir             (ir),
        .readdata_MEM   (readdata_MEM),
        .pc_out         (pc_out),
        .alu_DMEM       (alu_DMEM),
        .writedata_DMEM (writedata_DMEM),
        .memwrite_MEM   (memwrite_MEM)
    );

    mem imem (.clk(clk), .wen(loading & ld_wen), .addr(imem_addr), .wdata(ld_dat), .rdata(ir));
    mem dmem (.clk(clk), .wen(memwrite_MEM), .addr(alu_DMEM), .wdata(writedata_DMEM), .rdata(readdata_MEM));

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // write img[] into imem while the core is held in reset; returns at cycle 0 with rst released
    task automatic load_image();
        rst = 1'b1;
        loading = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ld_wen  = 1'b1;
            ld_addr = 32'(i) << 2;
            ld_dat  = img[i];
        end
        @(negedge clk);
        ld_wen  = 1'b0;
        loading = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; loading = 1'b0; ld_wen = 1'b0; ld_addr = '0; ld_dat = '0;

        prog_a[0]  = '{enc_i(12'd5, 5'd0, 3'd0, 5'd5, OPI), 5, 32'd5};
        prog_a[1]  = '{enc_i(12'd7, 5'd0, 3'd0, 5'd6, OPI), 6, 32'd7};
        prog_a[2]  = '{enc_r(7'd0, 5'd6, 5'd5, 3'd0, 5'd7), 7, 32'd12};
        prog_a[3]  = '{enc_s(12'd4, 5'd7, 5'd0), -1, 32'd0};
        prog_a[4]  = '{enc_i(12'd4, 5'd0, 3'd2, 5'd8, OPL), 8, 32'd12};
        prog_a[5]  = '{enc_r(7'd0, 5'd8, 5'd8, 3'd0, 5'd9), 9, 32'd24};
        prog_a[6]  = '{enc_b(13'd8, 5'd5, 5'd5, 3'd0), -1, 32'd0};
        prog_a[7]  = '{enc_i(12'd1, 5'd0, 3'd0, 5'd10, OPI), 10, 32'd0};
        prog_a[8]  = '{enc_i(12'd2, 5'd0, 3'd0, 5'd11, OPI), 11, 32'd2};
        prog_a[9]  = '{enc_i(12'd9, 5'd0, 3'd0, 5'd0, OPI), 0, 32'd0};
        prog_a[10] = '{enc_r(7'h20, 5'd6, 5'd5, 3'd0, 5'd12), 12, 32'hFFFF_FFFE};
        prog_a[11] = '{enc_r(7'd0, 5'd5, 5'd12, 3'd2, 5'd13), 13, 32'd1};
        prog_a[12] = '{enc_r(7'd0, 5'd5, 5'd12, 3'd3, 5'd14), 14, 32'd0};
        prog_a[13] = '{enc_i(12'h401, 5'd12, 3'd5, 5'd15, OPI), 15, 32'hFFFF_FFFF};
        prog_a[14] = '{enc_i(12'd28, 5'd12, 3'd5, 5'd16, OPI), 16, 32'h0000_000F};
        prog_a[15] = '{enc_u(20'h12345, 5'd17, OPLUI), 17, 32'h1234_5000};
        prog_a[16] = '{enc_i(12'hFFF, 5'd5, 3'd4, 5'd18, OPI), 18, 32'hFFFF_FFFA};
        prog_a[17] = '{enc_r(7'd0, 5'd5, 5'd6, 3'd7, 5'd19), 19, 32'd5};
        prog_a[18] = '{enc_r(7'd0, 5'd9, 5'd6, 3'd6, 5'd20), 20, 32'd31};
        prog_a[19] = '{enc_r(7'd0, 5'd6, 5'd5, 3'd1, 5'd21), 21, 32'd640};
        prog_a[20] = '{enc_u(20'h00001, 5'd22, OPAUI), 22, 32'h0000_1050};
        prog_a[21] = '{enc_b(13'd8, 5'd5, 5'd12, 3'd4), -1, 32'd0};
        prog_a[22] = '{enc_i(12'd1, 5'd0, 3'd0, 5'd23, OPI), 23, 32'd0};
        prog_a[23] = '{enc_b(13'd8, 5'd5, 5'd12, 3'd7), -1, 32'd0};
        prog_a[24] = '{enc_i(12'd1, 5'd0, 3'd0, 5'd24, OPI), 24, 32'd0};
        prog_a[25] = '{enc_i(12'h071, 5'd0, 3'd0, 5'd25, OPJR), 25, 32'h0000_0068};
        prog_a[26] = '{enc_i(12'd1, 5'd0, 3'd0, 5'd26, OPI), 26, 32'd0};
        prog_a[27] = '{enc_i(12'd1, 5'd0, 3'd0, 5'd27, OPI), 27, 32'd0};
        prog_a[28] = '{enc_i(12'd3, 5'd0, 3'd0, 5'd28, OPI), 28, 32'd3};

        prog_b[0]  = '{enc_i(12'd5, 5'd0, 3'd0, 5'd5, OPI), 5, 32'd5};
        prog_b[1]  = '{enc_b(13'd8, 5'd5, 5'd5, 3'd1), -1, 32'd0};
        prog_b[2]  = '{enc_i(12'd1, 5'd0, 3'd0, 5'd10, OPI), 10, 32'd1};
        prog_b[3]  = '{enc_i(12'd2, 5'd0, 3'd0, 5'd11, OPI), 11, 32'd2};
        for (int i = 4; i < 8; i++) prog_b[i] = '{32'h0000_0013, -1, 32'd0};
        prog_b[8]  = '{enc_j(21'd12, 5'd1), 1, 32'h0000_0024};
        prog_b[9]  = '{enc_i(12'd1, 5'd0, 3'd0, 5'd2, OPI), 2, 32'd0};
        prog_b[10] = '{enc_i(12'd1, 5'd0, 3'd0, 5'd3, OPI), 3, 32'd0};
        prog_b[11] = '{enc_i(12'd4, 5'd0, 3'd0, 5'd4, OPI), 4, 32'd4};

        // ---------- program A: forwarding, store/load, load-use, branches, jalr ----------
        for (int i = 0; i < 256; i++) img[i] = 32'h0000_0013;
        for (int i = 0; i < 29; i++)  img[i] = prog_a[i].instr;
        load_image();
        check("reset_pc_out", pc_out, 32'd0);
        check("reset_alu_DMEM", alu_DMEM, 32'd0);
        check("reset_writedata", writedata_DMEM, 32'd0);
        check("reset_memwrite", {31'd0, memwrite_MEM}, 32'd0);
        mw_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge clk);
            if (n < 12) check($sformatf("pc_trace_a[%0d]", n), pc_out, trace_a[n]);
            if (memwrite_MEM) begin
                mw_cnt++;
                check("sw_mem_cycle", n, 32'd6);
                check("sw_alu_DMEM", alu_DMEM, 32'd4);
                check("sw_writedata", writedata_DMEM, 32'd12);
            end
            if (n == 4) check("x5_before_wb", dut.regfile.registers[5], 32'd0);
            if (n == 5) check("x5_after_wb", dut.regfile.registers[5], 32'd5);
            if (n == 6) check("x7_before_wb", dut.regfile.registers[7], 32'd0);
            if (n == 7) check("x7_after_wb", dut.regfile.registers[7], 32'd12);
        end
        check("sw_pulse_count", mw_cnt, 32'd1);
        check("dmem_word1", dmem.mem[1], 32'd12);
        for (int i = 0; i < 29; i++) begin
            if (prog_a[i].chk_reg >= 0)
                check($sformatf("a_x%0d", prog_a[i].chk_reg), dut.regfile.registers[prog_a[i].chk_reg],
                      prog_a[i].chk_val);
        end

        // ---------- program B: not-taken bne, jal, mid-run reset ----------
        for (int i = 0; i < 256; i++) img[i] = 32'h0000_0013;
        for (int i = 0; i < 12; i++)  img[i] = prog_b[i].instr;
        load_image();
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (n < 14) check($sformatf("pc_trace_b[%0d]", n), pc_out, 32'(n) << 2);
        end
        for (int i = 0; i < 12; i++) begin
            if (prog_b[i].chk_reg >= 0)
                check($sformatf("b_x%0d", prog_b[i].chk_reg), dut.regfile.registers[prog_b[i].chk_reg],
                      prog_b[i].chk_val);
        end

        // restart, let the program get part-way, then reset with instructions in flight
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) @(negedge clk);
        check("rerun_x5", dut.regfile.registers[5], 32'd5);
        check("rerun_x10", dut.regfile.registers[10], 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pc_out", pc_out, 32'd0);
        check("midrst_memwrite", {31'd0, memwrite_MEM}, 32'd0);
        check("midrst_alu_DMEM", alu_DMEM, 32'd0);
        for (int r = 0; r < 32; r++) check($sformatf("midrst_x%0d", r), dut.regfile.registers[r], 32'd0);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) @(negedge clk);
        check("post_rst_pc", pc_out, 32'h18);
        check("post_rst_x1", dut.regfile.registers[1], 32'd0);
        check("post_rst_x5", dut.regfile.registers[5], 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
